// File: rtl/weight_update_if.sv
// Bundles the weight-update request operands and the result/status signals.
// The master drives the operands and start; the slave (weight_update) drives the results.
interface weight_update_if #(
    parameter int LAYER_IN          = 2,
    parameter int LAYER_OUT         = 2,
    parameter int DELTA_CELL_WIDTH  = 8,
    parameter int Z_CELL_WIDTH      = 8,
    parameter int WEIGHT_CELL_WIDTH = 8
);
    logic                                            start;
    logic [LAYER_OUT*DELTA_CELL_WIDTH-1:0]           delta;
    logic [LAYER_IN*Z_CELL_WIDTH-1:0]                z;
    logic [LAYER_OUT*LAYER_IN*WEIGHT_CELL_WIDTH-1:0] w;
    logic [LAYER_OUT*LAYER_IN*WEIGHT_CELL_WIDTH-1:0] w_updated;
    logic                                            busy;
    logic                                            valid;
    logic                                            error;

    modport master (
        output start, delta, z, w,
        input  w_updated, busy, valid, error
    );

    modport slave (
        input  start, delta, z, w,
        output w_updated, busy, valid, error
    );
endinterface

// File: rtl/weight_update.sv
// Applies W' = W - lr * (delta * z^T) one row per clock, saturating each result cell.
// Latency: start at edge 0, rows written at edges 1..LAYER_OUT, valid at edge LAYER_OUT; start ignored while busy.
module weight_update #(
    parameter int LAYER_IN          = 2,
    parameter int LAYER_OUT         = 2,
    parameter int DELTA_CELL_WIDTH  = 8,
    parameter int Z_CELL_WIDTH      = 8,
    parameter int WEIGHT_CELL_WIDTH = 8,
    parameter int FRACTION_WIDTH    = 4,
    parameter int LR_SHIFT          = 1
) (
    input  logic           clk,
    input  logic           rst,
    weight_update_if.slave bus
);
    localparam int DCW   = DELTA_CELL_WIDTH;
    localparam int ZCW   = Z_CELL_WIDTH;
    localparam int WCW   = WEIGHT_CELL_WIDTH;
    localparam int PW    = DCW + ZCW;
    localparam int DW    = ((PW > WCW) ? PW : WCW) + 1;
    localparam int SHIFT = FRACTION_WIDTH + LR_SHIFT;
    localparam int ROW_W = (LAYER_OUT > 1) ? $clog2(LAYER_OUT) : 1;
    localparam int DV_W  = LAYER_OUT * DCW;
    localparam int ZV_W  = LAYER_IN * ZCW;
    localparam int RW_W  = LAYER_IN * WCW;
    localparam int WV_W  = LAYER_OUT * RW_W;

    localparam logic signed [DW-1:0] SAT_MAX = {{(DW-WCW+1){1'b0}}, {(WCW-1){1'b1}}};
    localparam logic signed [DW-1:0] SAT_MIN = {{(DW-WCW+1){1'b1}}, {(WCW-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nxt;
    logic [ROW_W-1:0]  row, row_nxt;
    logic [DV_W-1:0]   delta_q, delta_nxt;
    logic [ZV_W-1:0]   z_q, z_nxt;
    logic [WV_W-1:0]   w_q, w_nxt;
    logic              busy_q, busy_nxt;
    logic              valid_q, valid_nxt;
    logic              error_q, error_nxt;

    // Datapath for the row currently selected by the sequencer
    logic [DCW-1:0]           delta_row;
    logic [RW_W-1:0]          w_row;
    logic [RW_W-1:0]          row_new;
    logic                     sat_any;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     grad;
    logic signed [DW-1:0]     w_ext;
    logic signed [DW-1:0]     g_ext;
    logic signed [DW-1:0]     diff;

    always_comb begin : row_math
        delta_row = delta_q[DCW-1:0];
        w_row     = w_q[RW_W-1:0];
        row_new   = '0;
        sat_any   = 1'b0;
        prod      = '0;
        grad      = '0;
        w_ext     = '0;
        g_ext     = '0;
        diff      = '0;
        for (int r = 0; r < LAYER_OUT; r++) begin
            if (row == ROW_W'(r)) begin
                delta_row = delta_q[r*DCW +: DCW];
                w_row     = w_q[r*RW_W +: RW_W];
            end
        end
        for (int c = 0; c < LAYER_IN; c++) begin
            prod  = $signed(delta_row) * $signed(z_q[c*ZCW +: ZCW]);
            // Arithmetic shift: rounds toward -inf, so tiny negative gradients become -1
            grad  = prod >>> SHIFT;
            w_ext = DW'($signed(w_row[c*WCW +: WCW]));
            g_ext = DW'(grad);
            diff  = w_ext - g_ext;
            if (diff > SAT_MAX) begin
                row_new[c*WCW +: WCW] = SAT_MAX[WCW-1:0];
                sat_any               = 1'b1;
            end else if (diff < SAT_MIN) begin
                row_new[c*WCW +: WCW] = SAT_MIN[WCW-1:0];
                sat_any               = 1'b1;
            end else begin
                row_new[c*WCW +: WCW] = diff[WCW-1:0];
            end
        end
    end

    always_comb begin : fsm_next
        state_nxt = state;
        row_nxt   = row;
        delta_nxt = delta_q;
        z_nxt     = z_q;
        w_nxt     = w_q;
        busy_nxt  = busy_q;
        valid_nxt = valid_q;
        error_nxt = error_q;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    delta_nxt = bus.delta;
                    z_nxt     = bus.z;
                    w_nxt     = bus.w;
                    valid_nxt = 1'b0;
                    error_nxt = 1'b0;
                    row_nxt   = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                for (int r = 0; r < LAYER_OUT; r++) begin
                    if (row == ROW_W'(r)) begin
                        w_nxt[r*RW_W +: RW_W] = row_new;
                    end
                end
                if (sat_any) begin
                    error_nxt = 1'b1;
                end
                if (row == ROW_W'(LAYER_OUT-1)) begin
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                    row_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    row_nxt = row + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            row     <= '0;
            delta_q <= '0;
            z_q     <= '0;
            w_q     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            row     <= row_nxt;
            delta_q <= delta_nxt;
            z_q     <= z_nxt;
            w_q     <= w_nxt;
            busy_q  <= busy_nxt;
            valid_q <= valid_nxt;
            error_q <= error_nxt;
        end
    end

    assign bus.w_updated = w_q;
    assign bus.busy      = busy_q;
    assign bus.valid     = valid_q;
    assign bus.error     = error_q;
endmodule

// File: tb/tb_weight_update.sv
// Directed bench for weight_update with hand-computed expected weights and flags.
module tb_weight_update;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    weight_update_if #(.LAYER_IN(2), .LAYER_OUT(2), .DELTA_CELL_WIDTH(8),
                       .Z_CELL_WIDTH(8), .WEIGHT_CELL_WIDTH(8)) bus ();

    weight_update #(
        .LAYER_IN(2), .LAYER_OUT(2), .DELTA_CELL_WIDTH(8), .Z_CELL_WIDTH(8),
        .WEIGHT_CELL_WIDTH(8), .FRACTION_WIDTH(4), .LR_SHIFT(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [15:0] d, input logic [15:0] zz, input logic [31:0] ww);
        bus.delta = d;
        bus.z     = zz;
        bus.w     = ww;
    endtask

    // Start pulse, then both row edges; returns just after the valid edge
    task automatic run(input logic [15:0] d, input logic [15:0] zz, input logic [31:0] ww);
        set_in(d, zz, ww);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
    endtask

    initial begin
        bus.start = 1'b0;
        set_in(16'h0, 16'h0, 32'h0);
        step();
        step();
        check("rst_w", bus.w_updated, 32'h0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_valid", {31'b0, bus.valid}, 32'd0);
        check("rst_error", {31'b0, bus.error}, 32'd0);
        rst = 1'b0;
        step();

        // Test 1: delta=[16,32], z=[16,-16], w=16 everywhere
        set_in(16'h2010, 16'hF010, 32'h10101010);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("t1_latch_w", bus.w_updated, 32'h10101010);
        check("t1_busy_e0", {31'b0, bus.busy}, 32'd1);
        check("t1_valid_e0", {31'b0, bus.valid}, 32'd0);
        step();
        check("t1_row0", bus.w_updated, 32'h10101808);
        check("t1_valid_e1", {31'b0, bus.valid}, 32'd0);
        step();
        check("t1_w", bus.w_updated, 32'h20001808);
        check("t1_valid_e2", {31'b0, bus.valid}, 32'd1);
        check("t1_busy_e2", {31'b0, bus.busy}, 32'd0);
        check("t1_error", {31'b0, bus.error}, 32'd0);
        step();
        check("t1_valid_hold", {31'b0, bus.valid}, 32'd1);

        // Test 2: positive and negative saturation
        run(16'h0080, 16'h007F, 32'h0000007F);
        check("t2_pos_w", bus.w_updated, 32'h0000007F);
        check("t2_pos_err", {31'b0, bus.error}, 32'd1);
        run(16'h007F, 16'h007F, 32'h00000080);
        check("t2_neg_w", bus.w_updated, 32'h00000080);
        check("t2_neg_err", {31'b0, bus.error}, 32'd1);

        // Test 3: shift truncates toward -inf
        run(16'h0001, 16'h00FF, 32'h0);
        check("t3_neg_trunc", bus.w_updated, 32'h00000001);
        check("t3_err", {31'b0, bus.error}, 32'd0);
        run(16'h0001, 16'h0001, 32'h0);
        check("t3_pos_trunc", bus.w_updated, 32'h0);

        // Test 4: start and operand changes while busy are ignored
        set_in(16'h2010, 16'hF010, 32'h10101010);
        bus.start = 1'b1;
        step();
        set_in(16'h807F, 16'h7F7F, 32'h80807F7F);
        step();
        check("t4_valid_e1", {31'b0, bus.valid}, 32'd0);
        step();
        check("t4_w", bus.w_updated, 32'h20001808);
        check("t4_valid_e2", {31'b0, bus.valid}, 32'd1);
        step();
        bus.start = 1'b0;
        check("t4_restart_valid", {31'b0, bus.valid}, 32'd0);
        check("t4_restart_busy", {31'b0, bus.busy}, 32'd1);
        step();
        step();
        check("t4_garbage_err", {31'b0, bus.error}, 32'd1);

        // Test 6: a clean run clears the sticky error on its start edge
        set_in(16'h2010, 16'hF010, 32'h10101010);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("t6_err_cleared", {31'b0, bus.error}, 32'd0);
        step();
        step();
        check("t6_w", bus.w_updated, 32'h20001808);
        check("t6_err", {31'b0, bus.error}, 32'd0);

        // Test 5: reset aborts a run
        set_in(16'h2010, 16'hF010, 32'h10101010);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_w", bus.w_updated, 32'h0);
        check("t5_busy", {31'b0, bus.busy}, 32'd0);
        check("t5_valid", {31'b0, bus.valid}, 32'd0);
        step();
        check("t5_no_valid", {31'b0, bus.valid}, 32'd0);
        run(16'h2010, 16'hF010, 32'h10101010);
        check("t5_rerun_w", bus.w_updated, 32'h20001808);
        check("t5_rerun_valid", {31'b0, bus.valid}, 32'd1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
